// File: rtl/tdc_uart_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : tdc_uart_framer_if
// Description : Valid/ready handshake carrying one TDC count into the framer.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_uart_framer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/tdc_uart_framer.sv
`default_nettype none
// ============================================================================
// Module      : tdc_uart_framer
// Description : Splits a TDC count into bytes and sends them as 8N1 UART.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_uart_framer #(
    parameter int          DATA_W       = 16,
    parameter int          CLKS_PER_BIT = 87,
    parameter int          SYNC_EN      = 1,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  wire logic        clk,
    input  wire logic        reset,
    tdc_uart_framer_if.slave bus,
    output logic             tx,
    output logic             eot,
    output logic             busy
);

    localparam int c_nb      = (DATA_W + 7) / 8;
    localparam int c_total   = c_nb + ((SYNC_EN != 0) ? 1 : 0);
    localparam int c_pad_w   = c_nb * 8;
    localparam int c_frame_w = c_total * 8;
    localparam int c_bit_cw  = $clog2(CLKS_PER_BIT);
    localparam int c_byte_cw = $clog2(c_total + 1);

    localparam logic [c_bit_cw-1:0]  c_bit_last  = c_bit_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_byte_cw-1:0] c_byte_last = c_byte_cw'(c_total - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_bit_cw-1:0]    r_bit_cnt;
    logic [2:0]             r_bit_idx;
    logic [c_byte_cw-1:0]   r_byte_cnt;
    logic [7:0]             r_shift;
    logic [c_frame_w-1:0]   r_frame;
    logic                   r_tx;
    logic                   r_eot;
    logic                   r_busy;
    logic                   r_ready;

    logic [c_pad_w-1:0]     w_padded;
    logic [c_frame_w-1:0]   w_frame;
    logic                   w_accept;
    logic                   w_bit_end;

    assign w_padded  = c_pad_w'(bus.data_in);
    assign w_accept  = bus.data_valid & r_ready;
    assign w_bit_end = (r_bit_cnt == c_bit_last);

    // Whole frame is laid out MSB-first so bytes leave from the top.
    generate
        if (SYNC_EN != 0) begin : g_sync
            assign w_frame = {SYNC_BYTE, w_padded};
        end else begin : g_nosync
            assign w_frame = w_padded;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_frame    <= '0;
            r_tx       <= 1'b1;
            r_eot      <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_eot <= 1'b0;
            if ((r_state == S_IDLE || r_state == S_DONE) && w_accept) begin
                r_state    <= S_START;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_shift    <= w_frame[c_frame_w-1 -: 8];
                r_frame    <= w_frame << 8;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
                r_ready    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_bit_cnt <= '0;
                            r_bit_idx <= '0;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_state   <= S_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_bit_cnt <= '0;
                            if (r_bit_idx == 3'd7) begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                                r_tx      <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (w_bit_end) begin
                            r_bit_cnt <= '0;
                            // Ready rises with eot so the next count lands on the DONE edge.
                            if (r_byte_cnt == c_byte_last) begin
                                r_state <= S_DONE;
                                r_eot   <= 1'b1;
                                r_ready <= 1'b1;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                                r_shift    <= r_frame[c_frame_w-1 -: 8];
                                r_frame    <= r_frame << 8;
                                r_tx       <= 1'b0;
                                r_state    <= S_START;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx             = r_tx;
    assign eot            = r_eot;
    assign busy           = r_busy;
    assign bus.data_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_tdc_uart_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_uart_framer
// Description : Directed bench for the framer: 16-bit/sync and 12-bit/no-sync.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_uart_framer;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic tx_a, eot_a, busy_a;
    logic tx_b, eot_b, busy_b;

    tdc_uart_framer_if #(.DATA_W(16)) if_a ();
    tdc_uart_framer_if #(.DATA_W(12)) if_b ();

    tdc_uart_framer #(
        .DATA_W(16), .CLKS_PER_BIT(CPB), .SYNC_EN(1), .SYNC_BYTE(8'hA5)
    ) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a), .tx(tx_a), .eot(eot_a), .busy(busy_a)
    );

    tdc_uart_framer #(
        .DATA_W(12), .CLKS_PER_BIT(CPB), .SYNC_EN(0), .SYNC_BYTE(8'hA5)
    ) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b), .tx(tx_b), .eot(eot_b), .busy(busy_b)
    );

    typedef struct {
        int          sel;
        logic [15:0] data;
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic cap_tx   [0:127];
    logic cap_eot  [0:127];
    logic cap_busy [0:127];
    logic cap_rdy  [0:127];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic g_tx(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction
    function automatic logic g_eot(input int sel);
        return (sel != 0) ? eot_b : eot_a;
    endfunction
    function automatic logic g_busy(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic g_rdy(input int sel);
        return (sel != 0) ? if_b.data_ready : if_a.data_ready;
    endfunction

    task automatic drive(input int sel, input logic valid, input logic [15:0] d);
        if (sel != 0) begin
            if_b.data_valid = valid;
            if_b.data_in    = d[11:0];
        end else begin
            if_a.data_valid = valid;
            if_a.data_in    = d;
        end
    endtask

    // Entered just after the accept edge; records cycles 1..F+1 and checks
    // them against an independent 8N1 reference waveform.
    task automatic capture_frame(input int sel, input int nb, input logic [7:0] e0,
                                 input logic [7:0] e1, input logic [7:0] e2, input string nm);
        int         f;
        int         wave_err, low_ref, low_dut, eot_cnt, busy_lo, rdy_hi;
        logic [7:0] exp_b [3];
        logic [7:0] dec;
        logic       bit_e;
        f = nb * 10 * CPB;
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
        for (int k = 1; k <= f + 1; k++) begin
            @(negedge clk);
            cap_tx[k]   = g_tx(sel);
            cap_eot[k]  = g_eot(sel);
            cap_busy[k] = g_busy(sel);
            cap_rdy[k]  = g_rdy(sel);
        end
        wave_err = 0; low_ref = 0; low_dut = 0; eot_cnt = 0; busy_lo = 0; rdy_hi = 0;
        for (int k = 1; k <= f; k++) begin
            int idx, j, b;
            idx = (k - 1) / CPB;
            j   = idx / 10;
            b   = idx % 10;
            if (b == 0)      bit_e = 1'b0;
            else if (b == 9) bit_e = 1'b1;
            else             bit_e = exp_b[j][b-1];
            if (!bit_e) low_ref++;
            if (cap_tx[k] !== 1'b1) low_dut++;
            if (cap_tx[k] !== bit_e) wave_err++;
            if (cap_eot[k] !== 1'b0) eot_cnt++;
            if (cap_busy[k] !== 1'b1) busy_lo++;
            if (cap_rdy[k] !== 1'b0) rdy_hi++;
        end
        for (int j = 0; j < nb; j++) begin
            for (int i = 0; i < 8; i++) dec[i] = cap_tx[1 + (10 * j + 1 + i) * CPB + CPB / 2];
            chk($sformatf("%s byte%0d", nm, j), 32'(dec), 32'(exp_b[j]));
        end
        chk({nm, " waveform_err_cycles"}, 32'(wave_err), 32'd0);
        chk({nm, " tx_low_cycles"}, 32'(low_dut), 32'(low_ref));
        chk({nm, " eot_early"}, 32'(eot_cnt), 32'd0);
        chk({nm, " eot_at_done"}, 32'(cap_eot[f+1]), 32'd1);
        chk({nm, " busy_gaps"}, 32'(busy_lo), 32'd0);
        chk({nm, " busy_at_done"}, 32'(cap_busy[f+1]), 32'd1);
        chk({nm, " ready_in_frame"}, 32'(rdy_hi), 32'd0);
        chk({nm, " ready_at_done"}, 32'(cap_rdy[f+1]), 32'd1);
        chk({nm, " tx_at_done"}, 32'(cap_tx[f+1]), 32'd1);
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        @(negedge clk);
        chk({nm, " ready_before"}, 32'(g_rdy(v.sel)), 32'd1);
        drive(v.sel, 1'b1, v.data);
        @(posedge clk);
        #1 drive(v.sel, 1'b0, v.data);
        capture_frame(v.sel, v.nbytes, v.b0, v.b1, v.b2, nm);
        @(negedge clk);
        chk({nm, " idle_busy"}, 32'(g_busy(v.sel)), 32'd0);
        chk({nm, " idle_eot"}, 32'(g_eot(v.sel)), 32'd0);
        chk({nm, " idle_ready"}, 32'(g_rdy(v.sel)), 32'd1);
        chk({nm, " idle_tx"}, 32'(g_tx(v.sel)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        vec_t v;
        vecs[0] = '{0, 16'h1234, 3, 8'hA5, 8'h12, 8'h34};
        vecs[1] = '{0, 16'h0000, 3, 8'hA5, 8'h00, 8'h00};
        vecs[2] = '{0, 16'hFFFF, 3, 8'hA5, 8'hFF, 8'hFF};
        vecs[3] = '{1, 16'h0ABC, 2, 8'h0A, 8'hBC, 8'h00};
        vecs[4] = '{1, 16'h0000, 2, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1, 16'h0FFF, 2, 8'h0F, 8'hFF, 8'h00};
        vecs[6] = '{0, 16'h8001, 3, 8'hA5, 8'h80, 8'h01};

        reset = 1'b1;
        drive(0, 1'b0, 16'h0);
        drive(1, 1'b0, 16'h0);

        // Reset held for 3 cycles and then released.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 3) reset = 1'b0;
            #1;
            chk($sformatf("rst%0d tx_a", c), 32'(tx_a), 32'd1);
            chk($sformatf("rst%0d eot_a", c), 32'(eot_a), 32'd0);
            chk($sformatf("rst%0d busy_a", c), 32'(busy_a), 32'd0);
            chk($sformatf("rst%0d ready_a", c), 32'(if_a.data_ready), 32'd1);
            chk($sformatf("rst%0d tx_b", c), 32'(tx_b), 32'd1);
            chk($sformatf("rst%0d ready_b", c), 32'(if_b.data_ready), 32'd1);
        end

        for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: valid held, data changes mid-frame; second value taken at DONE.
        @(negedge clk);
        drive(0, 1'b1, 16'h1111);
        @(posedge clk);
        #1 drive(0, 1'b1, 16'h2222);
        capture_frame(0, 3, 8'hA5, 8'h11, 8'h11, "bp_first");
        @(posedge clk);
        #1 drive(0, 1'b0, 16'h2222);
        capture_frame(0, 3, 8'hA5, 8'h22, 8'h22, "bp_second");
        @(negedge clk);
        chk("bp idle_busy", 32'(busy_a), 32'd0);
        chk("bp idle_tx", 32'(tx_a), 32'd1);

        // Reset during the second data byte (0x78), while its bit 0 is driving tx low.
        @(negedge clk);
        drive(0, 1'b1, 16'h5678);
        @(posedge clk);
        #1 drive(0, 1'b0, 16'h5678);
        repeat (86) @(negedge clk);
        chk("midrst tx_low_before", 32'(tx_a), 32'd0);
        chk("midrst busy_before", 32'(busy_a), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst tx_async", 32'(tx_a), 32'd1);
        chk("midrst ready_async", 32'(if_a.data_ready), 32'd1);
        chk("midrst busy_async", 32'(busy_a), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("midrst eot%0d", c), 32'(eot_a), 32'd0);
        end
        reset = 1'b0;
        v = '{0, 16'h00FF, 3, 8'hA5, 8'h00, 8'hFF};
        run_frame(v, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
